snake_game_core: RTL
====================

# snake_game_core

Game-logic and pixel-colour stage directly downstream of the video sync generator. Consumes the beam position, display-enable and sync strobes; holds snake, food, score and game state on a 16×15 grid of 16×16-pixel cells. Produces a registered 3-bit colour plus sync outputs delayed to match, ready for the top-level video pins.

## Interface
- `MAX_LEN`, 16: maximum snake segments, 2..16.
- `INIT_LEN`, 3: length after reset and restart, 2..MAX_LEN.
- `STEP_FRAMES`, 8: frames per snake move, ≥1.
- `clk`  in  1  pixel clock, the one clock.
- `reset`  in  1  asynchronous, active-low reset.
- `hpos`, `vpos`  in  9 each  beam position from the sync generator.
- `display_on`  in  1  beam in visible 256×240 area.
- `hsync`, `vsync`  in  1 each  sync strobes from the sync generator.
- `btn_up`, `btn_down`, `btn_left`, `btn_right`, `start`  in  1 each  synchronous, active-high controls.
- `rgb`  out  3  {r,g,b} pixel colour, registered.
- `hsync_o`, `vsync_o`  out  1 each  `hsync`/`vsync` delayed 1 cycle.
- `score`  out  8  food eaten, saturates at 255.
- `game_over`  out  1  high in OVER state.

## Operation
- **States:**
  - IDLE: snake drawn, no movement; `start` → RUN.
  - RUN: snake moves; a fatal step → OVER.
  - OVER: frozen; `start` → reinit, then RUN.
- **Init (reset or restart):**
  - seg[0]=(7,7) is the head; seg[1]=(6,7), seg[2]=(5,7); further segments continue leftward.
  - len=INIT_LEN, dir=pend=RIGHT, food=(11,7), score=0, frame counter=0.
  - Reset also forces state=IDLE and lfsr=8'hA5.
  - Restart from OVER does not reload lfsr.
- **Frame tick:** vsync rising edge, detected from a 1-cycle-registered copy of `vsync`. In RUN the frame counter increments on each tick. At STEP_FRAMES-1 it wraps to 0 and a step occurs in that cycle.
- **Direction:** each RUN cycle, a pressed button loads `pend`.
  - Priority when several are pressed: up > down > left > right.
  - A press opposite to `dir` (the last applied direction) is ignored.
  - At a step, `dir` <= `pend`.
- **Step:** nh = seg[0] moved one cell in `pend`. eat = (nh == food).
  - Wall death: x<0, x>15, y<0 or y>14.
  - Self death: nh equals seg[i] for i in 0..len-2. The range extends to len-1 when eat, because the tail does not vacate.
  - On death: state → OVER; segments, food, score and len are unchanged.
  - Otherwise: seg[i] <= seg[i-1] for i≥1, seg[0] <= nh.
  - If eat: len <= min(len+1, MAX_LEN); score <= sat(score+1); food <= (lfsr[7:4], lfsr[3:0]==15 ? 0 : lfsr[3:0]).
  - The new food may overlap the snake; this is accepted.
- **LFSR:** 8-bit Fibonacci, taps 8,6,5,4. Advances every cycle in all states. Never zero.
- **Render:** cell = (hpos[7:4], vpos[7:4]). Priority, highest first:
  - `display_on`=0 → 000.
  - Cell is seg[0] → 110 (yellow).
  - Cell is seg[1..len-1] → 010 (green).
  - Cell is food → 100 (red).
  - Background: 001 (blue) in OVER, else 000.
  - Segments at index ≥ len are ignored for render and collision.

## Timing
- **Reset values:** `rgb`=0, `hsync_o`=0, `vsync_o`=0, `score`=0, `game_over`=0.
- **Render latency:** `rgb` reflects the (hpos, vpos, display_on) sampled 1 cycle earlier, aligned with `hsync_o`/`vsync_o`.
- **Step timing:**
  - The step commits on the clock edge after the cycle in which the frame tick is detected.
  - `score`, `game_over`, `len` and the segments all update on that same edge.
  - Steps always fall in vertical blanking, so there is no tearing.
- **Start latency:** `start` in IDLE or OVER → state RUN on the next edge. The frame counter is cleared to 0 by that same start.
- **Simultaneous events:**
  - A button and a step in the same cycle: the step uses `pend` as it was before that cycle's button.
  - `start` in RUN is ignored.
- **Mid-operation reset:** reset asserted at any time forces the init values immediately (asynchronous). Deassertion is synchronised externally.

## Test plan
- **Reset:** reset low, then release, then scan one frame → `rgb`=110 at pixel (112,112); 010 at (96,112) and (80,112); 100 at (176,112); 000 elsewhere; `score`=0, `game_over`=0.
- **Move:** STEP_FRAMES=1, `start`, 4 frames with no buttons → head at (11,7) eats the food; `score`=1, len=4, new food = folded lfsr value.
- **Reversal and priority:** after `start`, press left → ignored, head reaches (8,7) after 1 step; then up+down together → up applied, next head is (8,6).
- **Wall:** `start`, then right for 9 steps → 9th step hits x=16; `game_over`=1, head stays at (15,7), background 001.
- **Self-collision:** grow to len=5, then steer up, left, down → `game_over`=1 on the step into own body.
- **Restart and latency:** `start` in OVER → `game_over`=0 and init positions next cycle; `rgb` lags `display_on` by exactly 1 clock; `hsync_o` equals `hsync` delayed 1 clock.

Source files
------------

// File: rtl/snake_game_core_if.sv
// Beam position, sync strobes and player controls into the snake core,
// and the registered colour, delayed sync and game status back out.
interface snake_game_core_if;
    logic [8:0] hpos;
    logic [8:0] vpos;
    logic       display_on;
    logic       hsync;
    logic       vsync;
    logic       btn_up;
    logic       btn_down;
    logic       btn_left;
    logic       btn_right;
    logic       start;
    logic [2:0] rgb;
    logic       hsync_o;
    logic       vsync_o;
    logic [7:0] score;
    logic       game_over;

    modport master (
        output hpos, vpos, display_on, hsync, vsync,
        output btn_up, btn_down, btn_left, btn_right, start,
        input  rgb, hsync_o, vsync_o, score, game_over
    );

    modport slave (
        input  hpos, vpos, display_on, hsync, vsync,
        input  btn_up, btn_down, btn_left, btn_right, start,
        output rgb, hsync_o, vsync_o, score, game_over
    );
endinterface

// File: rtl/snake_game_core.sv
// Snake game core: snake, food and score on a 16x15 grid stepped on vsync
// ticks, plus a registered per-pixel colour with sync delayed to match.
module snake_game_core #(
    parameter int MAX_LEN     = 16,
    parameter int INIT_LEN    = 3,
    parameter int STEP_FRAMES = 8
) (
    input  logic             clk,
    input  logic             reset,
    snake_game_core_if.slave bus
);
    localparam int LW = $clog2(MAX_LEN + 1);
    localparam int FW = (STEP_FRAMES > 1) ? $clog2(STEP_FRAMES) : 1;

    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_OVER = 2'd2} state_t;
    // Opposite directions differ only in bit 0.
    typedef enum logic [1:0] {DIR_RIGHT = 2'd0, DIR_LEFT = 2'd1, DIR_UP = 2'd2, DIR_DOWN = 2'd3} dir_t;

    state_t        state_q;
    dir_t          dir_q, pend_q;
    logic [3:0]    seg_x_q [MAX_LEN];
    logic [3:0]    seg_y_q [MAX_LEN];
    logic [LW-1:0] len_q;
    logic [3:0]    food_x_q, food_y_q;
    logic [7:0]    score_q, lfsr_q;
    logic [FW-1:0] frame_q;
    logic          game_over_q, vsync_q, hsync_q;
    logic [2:0]    rgb_q, rgb_d;

    logic       tick_s, step_s, wall_s, eat_s, self_hit_s, btn_any_s, btn_load_s;
    dir_t       btn_dir_s;
    logic [3:0] nh_x_s, nh_y_s, cell_x_s, cell_y_s;
    logic       head_hit_s, body_hit_s, food_hit_s, unused_s;

    function automatic logic [7:0] lfsr_next(input logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    assign tick_s     = bus.vsync & ~vsync_q;
    assign step_s     = (state_q == ST_RUN) && tick_s && (frame_q == FW'(STEP_FRAMES - 1));
    assign btn_load_s = (state_q == ST_RUN) && btn_any_s && (btn_dir_s != dir_t'(dir_q ^ 2'b01));
    assign unused_s   = ^{bus.hpos[8], bus.hpos[3:0], bus.vpos[8], bus.vpos[3:0]};

    assign bus.rgb       = rgb_q;
    assign bus.hsync_o   = hsync_q;
    assign bus.vsync_o   = vsync_q;
    assign bus.score     = score_q;
    assign bus.game_over = game_over_q;

    // Button priority encoder: up > down > left > right.
    always_comb begin
        btn_dir_s = DIR_RIGHT;
        btn_any_s = 1'b1;
        if (bus.btn_up)         btn_dir_s = DIR_UP;
        else if (bus.btn_down)  btn_dir_s = DIR_DOWN;
        else if (bus.btn_left)  btn_dir_s = DIR_LEFT;
        else if (bus.btn_right) btn_dir_s = DIR_RIGHT;
        else                    btn_any_s = 1'b0;
    end

    // Next head cell and the wall, food and self-collision tests for it.
    always_comb begin
        nh_x_s = seg_x_q[0];
        nh_y_s = seg_y_q[0];
        wall_s = 1'b0;
        case (pend_q)
            DIR_RIGHT: begin wall_s = (seg_x_q[0] == 4'd15); nh_x_s = seg_x_q[0] + 4'd1; end
            DIR_LEFT:  begin wall_s = (seg_x_q[0] == 4'd0);  nh_x_s = seg_x_q[0] - 4'd1; end
            DIR_UP:    begin wall_s = (seg_y_q[0] == 4'd0);  nh_y_s = seg_y_q[0] - 4'd1; end
            DIR_DOWN:  begin wall_s = (seg_y_q[0] == 4'd14); nh_y_s = seg_y_q[0] + 4'd1; end
            default:   wall_s = 1'b1;
        endcase
        eat_s      = (nh_x_s == food_x_q) && (nh_y_s == food_y_q);
        self_hit_s = 1'b0;
        // The tail cell only counts when eating, since then it does not vacate.
        for (int i = 0; i < MAX_LEN; i++) begin
            self_hit_s = self_hit_s | ((nh_x_s == seg_x_q[i]) && (nh_y_s == seg_y_q[i]) &&
                         (((i + 1) < int'(len_q)) || (eat_s && (i < int'(len_q)))));
        end
    end

    // Pixel colour for the current beam cell, highest priority first.
    always_comb begin
        cell_x_s   = bus.hpos[7:4];
        cell_y_s   = bus.vpos[7:4];
        head_hit_s = (cell_x_s == seg_x_q[0]) && (cell_y_s == seg_y_q[0]);
        food_hit_s = (cell_x_s == food_x_q) && (cell_y_s == food_y_q);
        body_hit_s = 1'b0;
        for (int i = 1; i < MAX_LEN; i++) begin
            body_hit_s = body_hit_s | ((cell_x_s == seg_x_q[i]) && (cell_y_s == seg_y_q[i]) &&
                         (i < int'(len_q)));
        end
        if (!bus.display_on)         rgb_d = 3'b000;
        else if (head_hit_s)         rgb_d = 3'b110;
        else if (body_hit_s)         rgb_d = 3'b010;
        else if (food_hit_s)         rgb_d = 3'b100;
        else if (state_q == ST_OVER) rgb_d = 3'b001;
        else                         rgb_d = 3'b000;
    end

    // Output pipeline: colour and both syncs share one register stage.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rgb_q   <= 3'b000;
            hsync_q <= 1'b0;
            vsync_q <= 1'b0;
        end else begin
            rgb_q   <= rgb_d;
            hsync_q <= bus.hsync;
            vsync_q <= bus.vsync;
        end
    end

    // Game state machine with snake, food, score and frame pacing.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            lfsr_q      <= 8'hA5;
            game_over_q <= 1'b0;
            len_q       <= LW'(INIT_LEN);
            dir_q       <= DIR_RIGHT;
            pend_q      <= DIR_RIGHT;
            food_x_q    <= 4'd11;
            food_y_q    <= 4'd7;
            score_q     <= 8'd0;
            frame_q     <= {FW{1'b0}};
            for (int i = 0; i < MAX_LEN; i++) begin
                seg_x_q[i] <= 4'(7 - i);
                seg_y_q[i] <= 4'd7;
            end
        end else begin
            lfsr_q <= lfsr_next(lfsr_q);
            case (state_q)
                ST_IDLE, ST_OVER: begin
                    if (bus.start) begin
                        state_q     <= ST_RUN;
                        game_over_q <= 1'b0;
                        len_q       <= LW'(INIT_LEN);
                        dir_q       <= DIR_RIGHT;
                        pend_q      <= DIR_RIGHT;
                        food_x_q    <= 4'd11;
                        food_y_q    <= 4'd7;
                        score_q     <= 8'd0;
                        frame_q     <= {FW{1'b0}};
                        for (int i = 0; i < MAX_LEN; i++) begin
                            seg_x_q[i] <= 4'(7 - i);
                            seg_y_q[i] <= 4'd7;
                        end
                    end
                end
                ST_RUN: begin
                    if (tick_s) begin
                        frame_q <= (frame_q == FW'(STEP_FRAMES - 1)) ? {FW{1'b0}} : frame_q + FW'(1);
                    end
                    if (btn_load_s) begin
                        pend_q <= btn_dir_s;
                    end
                    if (step_s) begin
                        dir_q <= pend_q;
                        if (wall_s || self_hit_s) begin
                            state_q     <= ST_OVER;
                            game_over_q <= 1'b1;
                        end else begin
                            for (int i = 1; i < MAX_LEN; i++) begin
                                seg_x_q[i] <= seg_x_q[i-1];
                                seg_y_q[i] <= seg_y_q[i-1];
                            end
                            seg_x_q[0] <= nh_x_s;
                            seg_y_q[0] <= nh_y_s;
                            if (eat_s) begin
                                if (len_q < LW'(MAX_LEN)) len_q <= len_q + LW'(1);
                                if (score_q != 8'd255)    score_q <= score_q + 8'd1;
                                food_x_q <= lfsr_q[7:4];
                                food_y_q <= (lfsr_q[3:0] == 4'd15) ? 4'd0 : lfsr_q[3:0];
                            end
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end
endmodule
